// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit saturating-counter direction predictor with init walk and statistics
module branch_predictor #(
   parameter int INDEX_BITS = 6,
   parameter int XLEN       = 32,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             lk_valid,
   input  logic [XLEN-1:0]  lk_pc,
   output logic             pred_valid,
   output logic             pred_taken,
   output logic             ready,
   input  logic             upd_valid,
   input  logic [XLEN-1:0]  upd_pc,
   input  logic             upd_taken,
   input  logic             upd_pred_taken,
   output logic             mispredict,
   output logic [CNT_W-1:0] br_count,
   output logic [CNT_W-1:0] miss_count
);
   localparam int ENTRIES = 1 << INDEX_BITS;
   typedef enum logic {INIT, RUN} state_t;
   state_t                state, state_nxt;
   logic [INDEX_BITS-1:0] init_idx;
   logic [1:0]            tbl [ENTRIES];
   logic [INDEX_BITS-1:0] lk_idx, upd_idx;
   logic [1:0]            upd_cur, upd_nxt;
   logic                  unused_pc;
   assign lk_idx    = lk_pc[INDEX_BITS+1:2];
   assign upd_idx   = upd_pc[INDEX_BITS+1:2];
   assign upd_cur   = tbl[upd_idx];
   assign ready     = state == RUN;
   assign unused_pc = ^{lk_pc[XLEN-1:INDEX_BITS+2], lk_pc[1:0], upd_pc[XLEN-1:INDEX_BITS+2], upd_pc[1:0]};
   // next state: leave INIT once the last entry is written; saturating counter step
   always_comb begin
      state_nxt = (state == INIT && (&init_idx)) ? RUN : state;
      upd_nxt   = upd_taken ? ((&upd_cur) ? upd_cur : upd_cur + 2'd1)
                            : ((|upd_cur) ? upd_cur - 2'd1 : upd_cur);
   end
   // state register and init walk pointer
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= INIT;
         init_idx <= '0;
      end else begin
         state    <= state_nxt;
         init_idx <= init_idx + INDEX_BITS'(state == INIT);
      end
   end
   // single write port: init walk owns it in INIT, training updates in RUN
   always_ff @(posedge clk) begin
      if (rst_n && state == INIT)
         tbl[init_idx] <= 2'b01;
      else if (rst_n && upd_valid)
         tbl[upd_idx] <= upd_nxt;
   end
   // registered prediction (read-before-write), mispredict pulse, saturating statistics
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pred_valid <= 1'b0;
         pred_taken <= 1'b0;
         mispredict <= 1'b0;
         br_count   <= '0;
         miss_count <= '0;
      end else begin
         pred_valid <= lk_valid;
         pred_taken <= lk_valid & ready & tbl[lk_idx][1];
         mispredict <= upd_valid & (upd_taken ^ upd_pred_taken);
         br_count   <= br_count + CNT_W'(upd_valid && !(&br_count));
         miss_count <= miss_count + CNT_W'(upd_valid && (upd_taken ^ upd_pred_taken) && !(&miss_count));
      end
   end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed and random checks against a table-of-integers reference model
module tb_branch_predictor;
   logic        clk = 0, rst_n = 0, lk_valid = 0, upd_valid = 0, upd_taken = 0, upd_pred_taken = 0;
   logic [31:0] lk_pc = 0, upd_pc = 0;
   logic        pred_valid, pred_taken, ready, mispredict;
   logic [31:0] br_count, miss_count;
   int          cnt [64];
   int          walk;
   bit          m_ready, e_pv, e_pt, e_mis;
   longint      e_br, e_miss;
   int          n_chk = 0, n_fail = 0;
   localparam longint MAXC = 64'hFFFF_FFFF;

   always #5 clk = ~clk;

   branch_predictor dut (
      .clk(clk), .rst_n(rst_n), .lk_valid(lk_valid), .lk_pc(lk_pc),
      .pred_valid(pred_valid), .pred_taken(pred_taken), .ready(ready),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .upd_pred_taken(upd_pred_taken), .mispredict(mispredict),
      .br_count(br_count), .miss_count(miss_count)
   );

   function automatic int idx(logic [31:0] pc);
      return (pc / 4) % 64;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // advance the model by one cycle, clock the DUT, compare every output
   task automatic tick();
      if (!rst_n) begin
         walk = 0; m_ready = 0; e_pv = 0; e_pt = 0; e_mis = 0; e_br = 0; e_miss = 0;
      end else begin
         e_pv  = lk_valid;
         e_pt  = lk_valid && m_ready && cnt[idx(lk_pc)] >= 2;
         e_mis = upd_valid && (upd_taken != upd_pred_taken);
         if (upd_valid && e_br < MAXC) e_br++;
         if (e_mis && e_miss < MAXC) e_miss++;
         if (!m_ready) begin
            cnt[walk] = 1;
            walk++;
            if (walk == 64) m_ready = 1;
         end else if (upd_valid) begin
            if (upd_taken) cnt[idx(upd_pc)] = (cnt[idx(upd_pc)] == 3) ? 3 : cnt[idx(upd_pc)] + 1;
            else           cnt[idx(upd_pc)] = (cnt[idx(upd_pc)] == 0) ? 0 : cnt[idx(upd_pc)] - 1;
         end
      end
      @(posedge clk); #1;
      chk("pred_valid", 32'(pred_valid), 32'(e_pv));
      chk("pred_taken", 32'(pred_taken), 32'(e_pt));
      chk("ready",      32'(ready),      32'(m_ready));
      chk("mispredict", 32'(mispredict), 32'(e_mis));
      chk("br_count",   br_count,        32'(e_br));
      chk("miss_count", miss_count,      32'(e_miss));
   endtask

   task automatic clr();
      lk_valid = 0; upd_valid = 0; upd_taken = 0; upd_pred_taken = 0;
   endtask

   task automatic idle(int n);
      clr();
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic upd(logic [31:0] pc, logic t, logic p);
      clr(); upd_valid = 1; upd_pc = pc; upd_taken = t; upd_pred_taken = p;
      tick(); clr();
   endtask

   task automatic look(logic [31:0] pc);
      clr(); lk_valid = 1; lk_pc = pc;
      tick(); clr();
   endtask

   initial begin
      for (int i = 0; i < 64; i++) cnt[i] = 0;
      rst_n = 0;
      idle(2);
      chk("reset_ready", 32'(ready), 0);
      chk("reset_br", br_count, 0);
      rst_n = 1;
      idle(63);
      chk("walk_ready_low", 32'(ready), 0);
      idle(1);
      chk("walk_ready_high", 32'(ready), 1);
      look(32'h40);
      chk("first_pv", 32'(pred_valid), 1);
      chk("first_pt", 32'(pred_taken), 0);
      upd(32'h10, 1, 0);
      chk("miss_pulse", 32'(mispredict), 1);
      chk("miss_br", br_count, 1);
      chk("miss_miss", miss_count, 1);
      upd(32'h10, 1, 1);
      chk("hit_pulse", 32'(mispredict), 0);
      chk("hit_br", br_count, 2);
      chk("hit_miss", miss_count, 1);
      upd(32'h100, 1, 0);
      look(32'h100);
      chk("train_t1", 32'(pred_taken), 1);
      for (int i = 0; i < 3; i++) upd(32'h100, 1, 1);
      upd(32'h100, 0, 1);
      look(32'h100);
      chk("st_nt1", 32'(pred_taken), 1);
      upd(32'h100, 0, 1);
      look(32'h100);
      chk("st_nt2", 32'(pred_taken), 0);
      upd(32'h100, 1, 0);
      upd(32'h100, 1, 1);
      look(32'h200);
      chk("alias_200", 32'(pred_taken), 1);
      look(32'h104);
      chk("alias_104", 32'(pred_taken), 0);
      upd(32'h100, 0, 1);
      upd(32'h100, 0, 1);
      clr(); lk_valid = 1; lk_pc = 32'h100; upd_valid = 1; upd_pc = 32'h100; upd_taken = 1; upd_pred_taken = 0;
      tick(); clr();
      chk("rbw_old", 32'(pred_taken), 0);
      look(32'h100);
      chk("rbw_new", 32'(pred_taken), 1);
      for (int i = 0; i < 400; i++) begin
         rst_n          = ($urandom_range(0, 99) != 0);
         lk_valid       = 1'($urandom());
         lk_pc          = $urandom();
         upd_valid      = 1'($urandom());
         upd_pc         = $urandom();
         upd_taken      = 1'($urandom());
         upd_pred_taken = 1'($urandom());
         tick();
      end
      rst_n = 1;
      idle(70);
      for (int i = 0; i < 6; i++) upd(32'h100, 1, 1);
      rst_n = 0;
      idle(1);
      chk("rerst_ready", 32'(ready), 0);
      chk("rerst_br", br_count, 0);
      chk("rerst_miss", miss_count, 0);
      rst_n = 1;
      for (int i = 0; i < 10; i++) upd(32'h100, 1, 0);
      idle(54);
      chk("rewalk_ready", 32'(ready), 1);
      for (int i = 0; i < 64; i++) begin
         look(32'(i * 4));
         chk("rewalk_pt", 32'(pred_taken), 0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
